// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the sram-like bus arbiter: source IDs, transfer
// size encodings and the default outstanding-transaction depth.
package sram_bus_arbiter_pkg;

  // Which master issued a transaction; stored per entry in the source FIFO.
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  // Transfer size encodings on the *_size buses.
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  localparam int unsigned OUTSTANDING_DEF = 2;

endpackage : sram_bus_arbiter_pkg

// File: rtl/sram_bus_arbiter_src_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per accepted, unreturned
// transaction. Pointers wrap at DEPTH, which need not be a power of two.
module sram_bus_arbiter_src_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = OUTSTANDING_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  src_e             push_src_i,
  input  logic             pop_i,
  output src_e             head_src_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  src_e             mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy; simultaneous push/pop keeps count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = ptr_inc(tail_q);
    if (pop_i)  head_d = ptr_inc(head_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Tag storage write port.
  // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_src_i;
  end

  assign head_src_o = mem_q[head_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);

endmodule : sram_bus_arbiter_src_fifo

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between the IF and MEM masters. Data has fixed
// priority, a presented-but-unaccepted request is locked until accepted, and
// responses are routed back in order using the source FIFO.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEF,
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  // IF master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // MEM master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // Shared slave port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_unexpected
);

  logic             lock_q, lock_d;
  src_e             lock_src_q, lock_src_d;
  logic             err_q, err_d;
  src_e             grant;
  src_e             head_src;
  logic             granted_req;
  logic             push, pop;
  logic             full, empty;
  logic [CNT_W-1:0] count;

  sram_bus_arbiter_src_fifo #(.DEPTH(OUTSTANDING)) u_src_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push),
    .push_src_i (grant),
    .pop_i      (pop),
    .head_src_o (head_src),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Grant selection and request-side muxing toward the shared port.
  always_comb begin
    if (lock_q)        grant = lock_src_q;
    else if (data_req) grant = SRC_DATA;
    else               grant = SRC_INST;

    if (grant == SRC_DATA) begin
      granted_req = data_req;
      mem_wr      = data_wr;
      mem_size    = data_size;
      mem_wstrb   = data_wstrb;
      mem_addr    = data_addr;
      mem_wdata   = data_wdata;
    end else begin
      granted_req = inst_req;
      mem_wr      = inst_wr;
      mem_size    = inst_size;
      mem_wstrb   = inst_wstrb;
      mem_addr    = inst_addr;
      mem_wdata   = inst_wdata;
    end
  end

  // Gating with resetn keeps every handshake low while reset is held.
  assign mem_req = granted_req & ~full & resetn;
  assign push    = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty;

  assign inst_addr_ok = push & (grant == SRC_INST);
  assign data_addr_ok = push & (grant == SRC_DATA);
  assign inst_data_ok = pop & (head_src == SRC_INST);
  assign data_data_ok = pop & (head_src == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Lock and sticky-error next state; a waiting request pins the grant.
  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    err_d      = err_q | (mem_data_ok & empty);
    if (mem_req && !mem_addr_ok) begin
      lock_d     = 1'b1;
      lock_src_d = grant;
    end else if (push) begin
      lock_d     = 1'b0;
    end
  end

  // Lock and error registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INST;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      err_q      <= err_d;
    end
  end

  assign err_unexpected = err_q;

endmodule : sram_bus_arbiter

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter. The bench plays the slave itself;
// inputs change 1 time unit after each rising edge, outputs are checked
// 1 unit later, well before the next edge.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_unexpected;

  int tests_run = 0;
  int tests_failed = 0;

  sram_bus_arbiter #(.OUTSTANDING(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_wstrb     (inst_wstrb),
    .inst_addr      (inst_addr),
    .inst_wdata     (inst_wdata),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_wstrb     (data_wstrb),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .mem_req        (mem_req),
    .mem_wr         (mem_wr),
    .mem_size       (mem_size),
    .mem_wstrb      (mem_wstrb),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_addr_ok    (mem_addr_ok),
    .mem_data_ok    (mem_data_ok),
    .mem_rdata      (mem_rdata),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let combinational paths settle after driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;

    // Reset state: handshakes and error flag low even with the slave asserting.
    #2;
    inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    chk_bit("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk_bit("rst_mem_req", mem_req, 1'b0);
    chk_bit("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk_bit("rst_err", err_unexpected, 1'b0);
    idle_inputs();
    #5 resetn = 1'b1;

    // S1: single inst read, accepted in cycle 0, returned in cycle 2.
    tick();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    chk_bit("s1_mem_req", mem_req, 1'b1);
    chk_word("s1_mem_addr", mem_addr, 32'h1C00_0000);
    chk_bit("s1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk_bit("s1_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk_bit("s1_c1_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'h0280_0000;
    #1;
    chk_bit("s1_inst_data_ok", inst_data_ok, 1'b1);
    chk_word("s1_inst_rdata", inst_rdata, 32'h0280_0000);
    chk_bit("s1_data_data_ok", data_data_ok, 1'b0);
    chk_bit("s1_err", err_unexpected, 1'b0);

    // S2: both request; data (a write) wins, inst follows; responses data then inst.
    tick();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_addr = 32'h8000_0010; data_wr = 1; data_wstrb = 4'hC;
    data_size = 2'd1; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    #1;
    chk_word("s2_mem_addr_data", mem_addr, 32'h8000_0010);
    chk_bit("s2_mem_wr", mem_wr, 1'b1);
    chk_word("s2_mem_wstrb", 32'(mem_wstrb), 32'hC);
    chk_word("s2_mem_size", 32'(mem_size), 32'd1);
    chk_word("s2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk_bit("s2_data_addr_ok", data_addr_ok, 1'b1);
    chk_bit("s2_inst_addr_ok_0", inst_addr_ok, 1'b0);
    tick();
    data_req = 0; data_wr = 0;
    #1;
    chk_word("s2_mem_addr_inst", mem_addr, 32'h1C00_0004);
    chk_bit("s2_mem_wr_inst", mem_wr, 1'b0);
    chk_bit("s2_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h1111_1111;
    #1;
    chk_bit("s2_r1_data_data_ok", data_data_ok, 1'b1);
    chk_bit("s2_r1_inst_data_ok", inst_data_ok, 1'b0);
    tick();
    mem_rdata = 32'h2222_2222;
    #1;
    chk_bit("s2_r2_inst_data_ok", inst_data_ok, 1'b1);
    chk_bit("s2_r2_data_data_ok", data_data_ok, 1'b0);
    chk_word("s2_r2_inst_rdata", inst_rdata, 32'h2222_2222);

    // S3: inst waits 3 cycles for addr_ok; data arriving meanwhile cannot preempt.
    tick();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0100; data_addr = 32'h8000_0200;
    #1;
    chk_word("s3_c0_mem_addr", mem_addr, 32'h1C00_0100);
    chk_bit("s3_c0_inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    data_req = 1;
    #1;
    chk_word("s3_c1_mem_addr_locked", mem_addr, 32'h1C00_0100);
    chk_bit("s3_c1_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    #1;
    chk_word("s3_c2_mem_addr_locked", mem_addr, 32'h1C00_0100);
    tick();
    mem_addr_ok = 1;
    #1;
    chk_word("s3_c3_mem_addr", mem_addr, 32'h1C00_0100);
    chk_bit("s3_c3_inst_addr_ok", inst_addr_ok, 1'b1);
    chk_bit("s3_c3_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    inst_req = 0;
    #1;
    chk_word("s3_c4_mem_addr_data", mem_addr, 32'h8000_0200);
    chk_bit("s3_c4_data_addr_ok", data_addr_ok, 1'b1);
    tick();
    idle_inputs();
    mem_data_ok = 1;
    #1;
    chk_bit("s3_r1_inst_data_ok", inst_data_ok, 1'b1);
    tick();
    #1;
    chk_bit("s3_r2_data_data_ok", data_data_ok, 1'b1);

    // S4: three back-to-back data requests against a 2-deep FIFO.
    tick();
    idle_inputs();
    data_req = 1; data_addr = 32'h0000_1000; mem_addr_ok = 1;
    #1;
    chk_bit("s4_req1_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_addr = 32'h0000_1004;
    #1;
    chk_bit("s4_req2_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_addr = 32'h0000_1008;
    #1;
    chk_bit("s4_full_mem_req", mem_req, 1'b0);
    chk_bit("s4_full_addr_ok", data_addr_ok, 1'b0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    #1;
    chk_bit("s4_pop_data_ok", data_data_ok, 1'b1);
    chk_bit("s4_pop_no_push_req", mem_req, 1'b0);
    chk_bit("s4_pop_no_push_ok", data_addr_ok, 1'b0);
    tick();
    mem_data_ok = 0;
    #1;
    chk_bit("s4_req3_mem_req", mem_req, 1'b1);
    chk_bit("s4_req3_addr_ok", data_addr_ok, 1'b1);
    tick();
    idle_inputs();
    mem_data_ok = 1;
    #1;
    chk_bit("s4_drain2", data_data_ok, 1'b1);
    tick();
    #1;
    chk_bit("s4_drain3", data_data_ok, 1'b1);
    chk_bit("s4_err_clear", err_unexpected, 1'b0);

    // S5: stray data_ok with empty FIFO; sticky error, async clear.
    tick();
    #1;
    chk_bit("s5_no_inst_data_ok", inst_data_ok, 1'b0);
    chk_bit("s5_no_data_data_ok", data_data_ok, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk_bit("s5_err_set", err_unexpected, 1'b1);
    tick();
    #1;
    chk_bit("s5_err_sticky", err_unexpected, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk_bit("s5_err_async_clear", err_unexpected, 1'b0);
    #1 resetn = 1'b1;

    // S6: reset with two outstanding; afterwards behaves as fresh.
    tick();
    data_req = 1; data_addr = 32'h0000_2000; mem_addr_ok = 1;
    tick();
    data_addr = 32'h0000_2004;
    #1;
    chk_bit("s6_second_push", data_addr_ok, 1'b1);
    tick();
    idle_inputs();
    #1 resetn = 1'b0;
    mem_data_ok = 1; inst_req = 1; mem_addr_ok = 1;
    #1;
    chk_bit("s6_rst_data_data_ok", data_data_ok, 1'b0);
    chk_bit("s6_rst_inst_addr_ok", inst_addr_ok, 1'b0);
    idle_inputs();
    #1 resetn = 1'b1;
    tick();
    inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
    #1;
    chk_bit("s6_mem_req", mem_req, 1'b1);
    chk_bit("s6_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    idle_inputs();
    tick();
    mem_data_ok = 1; mem_rdata = 32'h0280_0000;
    #1;
    chk_bit("s6_inst_data_ok", inst_data_ok, 1'b1);
    chk_bit("s6_data_data_ok", data_data_ok, 1'b0);
    chk_word("s6_inst_rdata", inst_rdata, 32'h0280_0000);
    tick();
    #1;
    chk_bit("s6_stray_inst", inst_data_ok, 1'b0);
    chk_bit("s6_stray_data", data_data_ok, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk_bit("s6_count_was_one", err_unexpected, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sram_bus_arbiter

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch master (IF stage) and the data master (MEM stage).
- Grants address phases by fixed priority, with a hold rule once a request is presented.
- Records the source of each accepted request in an in-order outstanding FIFO.
- Routes each returned data_ok/rdata to the master that issued it.
- Sits between the pipeline stages and the downstream sram-like-to-AXI bridge.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unreturned transactions (1..8).
- CNT_W, $clog2(OUTSTANDING+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req, inst_wr  in  1 each  IF master request / write flag.
- inst_size  in  2  0:1B 1:2B 2:4B.
- inst_wstrb  in  4  write strobes.
- inst_addr, inst_wdata  in  32 each  address / write data.
- inst_addr_ok, inst_data_ok  out  1 each  IF handshakes.
- inst_rdata  out  32  IF read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  MEM master, same meaning.
- data_addr_ok, data_data_ok  out  1 each  MEM handshakes.
- data_rdata  out  32  MEM read data.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared port.
- mem_addr_ok, mem_data_ok  in  1 each  slave handshakes; slave returns responses in order.
- mem_rdata  in  32  slave read data.
- err_unexpected  out  1  sticky flag: mem_data_ok seen with FIFO empty.

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO pointers and count = 0; lock = 0; lock_src = 0; err_unexpected = 0.
  - All *_addr_ok and *_data_ok outputs are low while reset is held.
  - Any in-flight transaction is discarded; the slave is reset by the same signal.
- full = (count == OUTSTANDING).
  - While full, mem_req = 0 and both addr_ok outputs = 0.
  - A pop in the same cycle does not lift full; no push+pop bypass.
- Grant, combinational:
  - If lock = 1, grant = lock_src.
  - Otherwise grant = data if data_req, else inst.
  - Encoding: src 0 = inst, 1 = data.
- Lock, registered:
  - Set when mem_req = 1 and mem_addr_ok = 0; lock_src = grant.
  - Cleared on the cycle mem_req & mem_addr_ok.
  - Purpose: a presented request cannot be preempted before it is accepted (the bridge latches on req).
- mem_req = granted master's req & ~full.
- mem_wr/size/wstrb/addr/wdata are muxed from the granted master.
- Address handshake:
  - granted_addr_ok = mem_addr_ok & mem_req.
  - The non-granted master's addr_ok = 0.
- Push: on mem_req & mem_addr_ok, write the grant bit at the tail; tail++ mod OUTSTANDING; count++.
- Pop: on mem_data_ok with count != 0:
  - Read the src bit at head.
  - Assert that master's data_ok combinationally, same cycle as mem_data_ok; rdata = mem_rdata.
  - head++ mod OUTSTANDING; count--.
  - Applies to writes too: a write's data_ok signals completion.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Wrap-around: pointers wrap at OUTSTANDING, not at a power of two.
- mem_data_ok with count == 0: no data_ok to either master; set err_unexpected (cleared only by reset).
- inst_rdata/data_rdata drive mem_rdata unconditionally; valid only with the matching data_ok.
- Latency: zero added cycles on either address or data phase; the arbiter adds only muxing.
- The arbiter never drops responses. The IF stage discards cancelled fetches itself (its drop state), so it still receives one inst_data_ok per accepted fetch.

Decomposition:
- Shared package holds:
  - SRC_INST = 1'b0 and SRC_DATA = 1'b1.
  - SIZE_B/SIZE_H/SIZE_W encodings.
  - OUTSTANDING default.
- One natural sub-module: src_fifo, an OUTSTANDING-deep, 1-bit-wide in-order FIFO with count and full/empty.
- Grant, lock and muxing stay in the top.

Test Plan:
- Only inst_req=1 to addr 0x1C000000, slave addr_ok same cycle, data_ok 2 cycles later with rdata 0x02800000 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x02800000 in cycle 2; data_data_ok stays 0.
- inst_req and data_req both 1, slave addr_ok=1 -> data granted first (mem_addr = data_addr); inst granted next cycle; responses route data then inst.
- inst_req=1, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> mem_addr stays inst_addr until accepted (lock); then data is granted.
- OUTSTANDING=2, three back-to-back requests, no data_ok -> third request sees mem_req=0 and addr_ok=0 until the first data_ok; the first data_ok pop does not allow a push that same cycle; the third is accepted on the following cycle.
- mem_data_ok pulse with FIFO empty -> no master data_ok; err_unexpected=1 and stays 1; resetn low clears it asynchronously.
- resetn asserted with 2 outstanding -> count=0; a subsequent single request behaves as in the first scenario.
